// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter.
//
// Accepts a WIDTH-bit word through a load/ready handshake and sends a frame on
// `out`: one start bit (0), WIDTH data bits (LSB or MSB first), an optional
// even-parity bit, then STOP_BITS stop bits (1). Every bit is held for
// CLKS_PER_BIT clocks. All outputs are registered.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-low reset
//   din   - parallel word, captured only on an accepted load
//   load  - transmit request, accepted when ready is high
//   ready - high when a load will be accepted
//   out   - serial line, idles high
//   busy  - high while a frame is in progress
//   done  - one-cycle pulse at frame completion
module piso_frame_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             busy,
    output logic             done
);

    // The whole stop interval is counted as one run of cycles, so the cycle
    // counter is sized for the longer of one bit period and the stop interval.
    localparam int unsigned StopCycles = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CntW       = (StopCycles > 1) ? $clog2(StopCycles) : 1;
    localparam int unsigned BitW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CntW-1:0] CycLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] StopLast = CntW'(StopCycles - 2);
    localparam logic [BitW-1:0] BitLast  = BitW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]   cyc_cnt_q, cyc_cnt_d;
    logic              parity_q, parity_d;
    logic              out_q, out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cyc_wrap;
    logic              next_bit;
    logic [WIDTH-1:0]  shreg_shifted;
    logic              enter_stop;
    logic              finish;

    assign cyc_wrap      = (cyc_cnt_q == CycLast);
    assign next_bit      = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;
        parity_d   = parity_q;
        out_d      = out_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        enter_stop = 1'b0;
        finish     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load && ready_q) begin
                    shreg_d   = din;
                    parity_d  = ^din;
                    bit_cnt_d = '0;
                    cyc_cnt_d = '0;
                    out_d     = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (cyc_wrap) begin
                    cyc_cnt_d = '0;
                    out_d     = next_bit;
                    shreg_d   = shreg_shifted;
                    state_d   = StData;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cyc_wrap) begin
                    cyc_cnt_d = '0;
                    if (bit_cnt_q == BitLast) begin
                        if (PARITY_EN != 0) begin
                            out_d   = parity_q;
                            state_d = StParity;
                        end else begin
                            enter_stop = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        out_d     = next_bit;
                        shreg_d   = shreg_shifted;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (cyc_wrap) begin
                    enter_stop = 1'b1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cyc_cnt_q == StopLast) begin
                    finish = 1'b1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter_stop) begin
            out_d     = 1'b1;
            cyc_cnt_d = '0;
            if (StopCycles == 1) begin
                finish = 1'b1;
            end else begin
                state_d = StStop;
            end
        end

        // Completion is registered one edge early: the idle/done cycle is also
        // the final stop cycle, so a load seen alongside done starts the next
        // frame straight after the stop bit with no extra idle cycle.
        if (finish) begin
            state_d   = StIdle;
            cyc_cnt_d = '0;
            out_d     = 1'b1;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            parity_q  <= 1'b0;
            out_q     <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
            parity_q  <= parity_d;
            out_q     <= out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out   = out_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
